get_input_multi: RTL and testbench
==================================

Name: get_input_multi

Overview:
- Parametrised successor to the two-button input capture block.
- Synchronises and debounces N_CH button inputs plus a dedicated user-reset button.
- Runs a request/capture handshake: on e_inp it waits for buttons released, captures the first new press, reports it with a one-cycle d_inp_o pulse, and holds the result until the request drops.
- Adds an optional capture timeout; sits between board buttons and the game/control FSM.

Parameters:
N_CH, 4, number of button channels (>=1)
DB_CYCLES, 2, consecutive stable cycles required to change a debounced level; 0 = no debounce (synchroniser only)
TIMEOUT, 0, max cycles waiting for a press; 0 = never time out
CW, $clog2(N_CH) min 1, width of ch_idx_o (derived, not overridden)

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous active-low reset
e_inp  in  1  capture request (level)
btn_i  in  N_CH  raw asynchronous buttons, active-high
rst_btn_i  in  1  raw user-reset button, active-high
btn_o  out  N_CH  one-hot captured button, held until next capture/abort
ch_idx_o  out  CW  binary index of captured button
d_inp_o  out  1  one-cycle pulse: capture done
timeout_o  out  1  one-cycle pulse: request timed out
busy_o  out  1  high in ARM and WAIT
rst_o  out  1  one-cycle pulse on debounced rst_btn_i rising edge
btn_lvl_o  out  N_CH  debounced levels (monitoring)

Behaviour:
- Async reset (rst_ni=0): all flops 0; outputs 0; FSM=IDLE.
- Per channel (incl. reset button): 2-FF synchroniser.
- Debounce counter: width $clog2(DB_CYCLES+1).
  - Counter clears when synced == debounced.
  - Counter increments when they differ.
  - Debounced level flips when it differs for DB_CYCLES consecutive edges; the counter clears at the same edge.
  - Glitches shorter than DB_CYCLES cycles never reach btn_lvl_o.
- Rise detect: registered (deb & ~deb_d).
- Latency: btn_i stable high first sampled at edge 1 -> d_inp_o high after edge DB_CYCLES+3.
- FSM states: IDLE, ARM, WAIT, DONE.
  - IDLE: busy_o=0. e_inp=1 -> ARM. Rises in IDLE are ignored.
  - ARM: wait until btn_lvl_o==0 (release check) -> WAIT. A button held from the previous capture is never re-captured.
  - WAIT:
    - On any channel rise: btn_o = one-hot of the lowest-index rising channel, ch_idx_o = its index, d_inp_o=1 for one cycle -> DONE.
    - Simultaneous rises: lowest index wins; the others are discarded.
    - TIMEOUT>0: cycle counter from 0 on WAIT entry. When it reaches TIMEOUT with no rise: timeout_o pulse, btn_o=0, ch_idx_o=0 -> DONE.
    - A rise in the same cycle as the timeout: the capture wins, no timeout_o.
  - DONE: outputs held. e_inp=0 -> IDLE. btn_o/ch_idx_o stay valid until the next capture or abort.
  - Abort: e_inp=0 in ARM or WAIT -> IDLE; btn_o and ch_idx_o cleared; no d_inp_o, no timeout_o.
- Reset button:
  - Debounced rise -> rst_o pulse for one cycle.
  - Same edge: synchronous soft reset of FSM to IDLE; btn_o, ch_idx_o and the timeout counter cleared.
  - Has priority over a capture or timeout in the same cycle (d_inp_o suppressed).
  - Synchronisers and debouncers are not cleared.
- d_inp_o and timeout_o are mutually exclusive; each is at most one cycle per request.
- Re-assertion: e_inp held high in DONE does not start a new capture; it must go low, then high.

Test Plan:
- N_CH=4, DB_CYCLES=2, TIMEOUT=0: e_inp=1, all released, btn_i=4'b0100 held -> d_inp_o single pulse at edge 5 after the first sampling edge; btn_o=4'b0100, ch_idx_o=2; busy_o=0 in DONE.
- Bounce: btn_i[1] toggles every cycle for 10 cycles, then held high -> btn_lvl_o[1] stays 0 during bounce; exactly one d_inp_o, ch_idx_o=1.
- Held button: btn_i[0]=1 before e_inp rises -> no capture while held; release, press btn_i[3] -> ch_idx_o=3.
- Simultaneous press btn_i=4'b1010 in one cycle -> btn_o=4'b0010, ch_idx_o=1; de-assert e_inp -> IDLE, btn_o still 4'b0010.
- TIMEOUT=50: e_inp=1, no press -> timeout_o pulse exactly 50 cycles after WAIT entry, btn_o=0. Separately, drop e_inp at cycle 20 -> IDLE with no pulses.
- rst_btn_i pressed in WAIT together with btn_i[2] -> rst_o pulse, d_inp_o stays 0, FSM IDLE. Separately, rst_ni=0 mid-DONE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/get_input_multi.sv
// ---------------------------------------------------------------------------
// get_input_multi
//
// Button capture front end between the board buttons and the game/control
// FSM. Every button (plus a dedicated user-reset button) passes through a
// 2-FF synchroniser and a counter debouncer. A request/capture handshake
// then waits for all buttons to be released, captures the first new press,
// reports it with a one-cycle pulse and holds the result until the request
// drops. An optional timeout ends a request that never sees a press.
//
// Parameters
//   N_CH      : number of button channels (>= 1)
//   DB_CYCLES : consecutive stable cycles needed to change a debounced level
//               (0 = synchroniser only)
//   TIMEOUT   : max cycles waiting for a press (0 = never time out)
//   CW        : width of ch_idx_o, derived from N_CH
//
// Ports
//   clk_i      : system clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   e_inp      : capture request (level)
//   btn_i      : raw asynchronous buttons, active-high
//   rst_btn_i  : raw user-reset button, active-high
//   btn_o      : one-hot captured button, held until next capture/abort
//   ch_idx_o   : binary index of the captured button
//   d_inp_o    : one-cycle pulse, capture done
//   timeout_o  : one-cycle pulse, request timed out
//   busy_o     : high while arming or waiting for a press
//   rst_o      : one-cycle pulse on a debounced user-reset press
//   btn_lvl_o  : debounced button levels
// ---------------------------------------------------------------------------
module get_input_multi #(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 2,
    parameter int TIMEOUT   = 0,
    localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            e_inp,
    input  logic [N_CH-1:0] btn_i,
    input  logic            rst_btn_i,
    output logic [N_CH-1:0] btn_o,
    output logic [CW-1:0]   ch_idx_o,
    output logic            d_inp_o,
    output logic            timeout_o,
    output logic            busy_o,
    output logic            rst_o,
    output logic [N_CH-1:0] btn_lvl_o
);

    // The reset button rides along as the top channel of the input pipeline.
    localparam int NB  = N_CH + 1;
    localparam int DBW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync_1;
    logic [NB-1:0] sync_2;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_d;
    logic [NB-1:0] rise;

    assign raw = {rst_btn_i, btn_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_1 <= '0;
            sync_2 <= '0;
            deb_d  <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            deb_d  <= deb;
        end
    end

    // Debounce: the counter only runs while the synchronised input disagrees
    // with the current level, so any glitch shorter than DB_CYCLES resets it.
    generate
        if (DB_CYCLES == 0) begin : g_no_db
            assign deb = sync_2;
        end else begin : g_db
            for (genvar g = 0; g < NB; g++) begin : g_ch
                logic [DBW-1:0] cnt;
                logic           lvl;

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        cnt <= '0;
                        lvl <= 1'b0;
                    end else if (sync_2[g] == lvl) begin
                        cnt <= '0;
                    end else if (cnt == DBW'(DB_CYCLES - 1)) begin
                        lvl <= sync_2[g];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                assign deb[g] = lvl;
            end
        end
    endgenerate

    assign rise = deb & ~deb_d;

    // Lowest-index rising channel wins; the loop runs high to low so the
    // last assignment is the lowest index.
    logic          pick_hit;
    logic [CW-1:0] pick_idx;

    always_comb begin
        pick_hit = 1'b0;
        pick_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rise[i]) begin
                pick_hit = 1'b1;
                pick_idx = CW'(i);
            end
        end
    end

    state_t          state, state_n;
    logic [N_CH-1:0] btn_q, btn_n;
    logic [CW-1:0]   idx_q, idx_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic            done_q, done_n;
    logic            to_q, to_n;
    logic            rst_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            btn_q  <= '0;
            idx_q  <= '0;
            tcnt   <= '0;
            done_q <= 1'b0;
            to_q   <= 1'b0;
            rst_q  <= 1'b0;
        end else begin
            state  <= state_n;
            btn_q  <= btn_n;
            idx_q  <= idx_n;
            tcnt   <= tcnt_n;
            done_q <= done_n;
            to_q   <= to_n;
            rst_q  <= rise[N_CH];
        end
    end

    // Priority: user-reset press, then request drop (abort), then capture,
    // then timeout. The result registers are only touched by a capture,
    // a timeout, an abort or the user-reset press.
    always_comb begin
        state_n = state;
        btn_n   = btn_q;
        idx_n   = idx_q;
        tcnt_n  = tcnt;
        done_n  = 1'b0;
        to_n    = 1'b0;

        if (rise[N_CH]) begin
            state_n = IDLE;
            btn_n   = '0;
            idx_n   = '0;
            tcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (e_inp) state_n = ARM;
                end
                ARM: begin
                    if (!e_inp) begin
                        state_n = IDLE;
                        btn_n   = '0;
                        idx_n   = '0;
                    end else if (deb[N_CH-1:0] == '0) begin
                        state_n = WAIT;
                        tcnt_n  = '0;
                    end
                end
                WAIT: begin
                    if (!e_inp) begin
                        state_n = IDLE;
                        btn_n   = '0;
                        idx_n   = '0;
                        tcnt_n  = '0;
                    end else if (pick_hit) begin
                        state_n = DONE;
                        btn_n   = N_CH'(1) << pick_idx;
                        idx_n   = pick_idx;
                        done_n  = 1'b1;
                    end else if ((TIMEOUT > 0) && (tcnt == TW'(TIMEOUT - 1))) begin
                        state_n = DONE;
                        btn_n   = '0;
                        idx_n   = '0;
                        to_n    = 1'b1;
                    end else if (TIMEOUT > 0) begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!e_inp) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign btn_o     = btn_q;
    assign ch_idx_o  = idx_q;
    assign d_inp_o   = done_q;
    assign timeout_o = to_q;
    assign rst_o     = rst_q;
    assign busy_o    = (state == ARM) || (state == WAIT);
    assign btn_lvl_o = deb[N_CH-1:0];

endmodule

// File: tb/tb_get_input_multi.sv
// ---------------------------------------------------------------------------
// tb_get_input_multi
//
// Bench for get_input_multi with N_CH=4, DB_CYCLES=2, TIMEOUT=50. A
// behavioural model tracks the expected outputs from the input history and
// is compared against the DUT on every falling clock edge; directed
// scenarios add hand-computed expectations on top.
// ---------------------------------------------------------------------------
module tb_get_input_multi;

    localparam int N_CH      = 4;
    localparam int DB_CYCLES = 2;
    localparam int TIMEOUT   = 50;
    localparam int CW        = 2;

    logic            clk_i     = 1'b0;
    logic            rst_ni    = 1'b0;
    logic            e_inp     = 1'b0;
    logic [N_CH-1:0] btn_i     = '0;
    logic            rst_btn_i = 1'b0;
    logic [N_CH-1:0] btn_o;
    logic [CW-1:0]   ch_idx_o;
    logic            d_inp_o;
    logic            timeout_o;
    logic            busy_o;
    logic            rst_o;
    logic [N_CH-1:0] btn_lvl_o;

    int checks   = 0;
    int failures = 0;
    int cnt_d    = 0;
    int cnt_to   = 0;
    int cnt_rst  = 0;

    get_input_multi #(
        .N_CH      (N_CH),
        .DB_CYCLES (DB_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .e_inp     (e_inp),
        .btn_i     (btn_i),
        .rst_btn_i (rst_btn_i),
        .btn_o     (btn_o),
        .ch_idx_o  (ch_idx_o),
        .d_inp_o   (d_inp_o),
        .timeout_o (timeout_o),
        .busy_o    (busy_o),
        .rst_o     (rst_o),
        .btn_lvl_o (btn_lvl_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Drive inputs just after a rising edge, then run n cycles, counting the
    // pulses seen after each edge.
    task automatic applyStimulus(input logic e, input logic [N_CH-1:0] b,
                                 input logic r, input int n);
        e_inp     = e;
        btn_i     = b;
        rst_btn_i = r;
        repeat (n) begin
            @(posedge clk_i);
            #2;
            cnt_d   += int'(d_inp_o);
            cnt_to  += int'(timeout_o);
            cnt_rst += int'(rst_o);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: input history, per-channel run lengths, and a
    // request described by three flags (waiting for release, listening
    // for a press, holding a result).
    // ------------------------------------------------------------------
    logic [N_CH:0]   m_h1 = '0, m_h2 = '0, m_lvl = '0, m_lvl_d = '0;
    logic [N_CH:0]   m_now, m_rise;
    int              m_run [N_CH+1];
    bit              m_release = 0, m_listen = 0, m_hold = 0, m_found;
    int              m_wcnt = 0;
    logic [N_CH-1:0] m_btn = '0;
    int              m_idx = 0;
    bit              m_done = 0, m_to = 0, m_rst = 0;
    bit              model_live = 0;

    initial forever begin
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni) begin
            m_h1 = '0; m_h2 = '0; m_lvl = '0; m_lvl_d = '0;
            for (int c = 0; c <= N_CH; c++) m_run[c] = 0;
            m_release = 0; m_listen = 0; m_hold = 0; m_wcnt = 0;
            m_btn = '0; m_idx = 0; m_done = 0; m_to = 0; m_rst = 0;
        end else begin
            model_live = 1;
            m_now  = m_lvl;
            m_rise = m_lvl & ~m_lvl_d;
            m_done = 0;
            m_to   = 0;
            m_rst  = m_rise[N_CH];
            if (m_rise[N_CH]) begin
                m_release = 0; m_listen = 0; m_hold = 0;
                m_btn = '0; m_idx = 0; m_wcnt = 0;
            end else if (m_release) begin
                if (!e_inp) begin
                    m_release = 0; m_btn = '0; m_idx = 0;
                end else if (m_now[N_CH-1:0] == '0) begin
                    m_release = 0; m_listen = 1; m_wcnt = 0;
                end
            end else if (m_listen) begin
                if (!e_inp) begin
                    m_listen = 0; m_btn = '0; m_idx = 0;
                end else if (m_rise[N_CH-1:0] != '0) begin
                    m_found = 0;
                    for (int i = 0; i < N_CH; i++) begin
                        if (m_rise[i] && !m_found) begin
                            m_found = 1; m_idx = i; m_btn = '0; m_btn[i] = 1'b1;
                        end
                    end
                    m_done = 1; m_listen = 0; m_hold = 1;
                end else begin
                    m_wcnt++;
                    if (TIMEOUT > 0 && m_wcnt == TIMEOUT) begin
                        m_to = 1; m_btn = '0; m_idx = 0; m_listen = 0; m_hold = 1;
                    end
                end
            end else if (m_hold) begin
                if (!e_inp) m_hold = 0;
            end else if (e_inp) begin
                m_release = 1;
            end
            for (int c = 0; c <= N_CH; c++) begin
                if (m_h2[c] == m_lvl[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] >= DB_CYCLES) begin
                        m_lvl[c] = m_h2[c];
                        m_run[c] = 0;
                    end
                end
            end
            m_h2    = m_h1;
            m_h1    = {rst_btn_i, btn_i};
            m_lvl_d = m_now;
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk_i);
        if (model_live) begin
            checkOutput("cyc d_inp_o",   d_inp_o,   m_done);
            checkOutput("cyc timeout_o", timeout_o, m_to);
            checkOutput("cyc rst_o",     rst_o,     m_rst);
            checkOutput("cyc busy_o",    busy_o,    m_release || m_listen);
            checkOutput("cyc btn_o",     btn_o,     m_btn);
            checkOutput("cyc ch_idx_o",  ch_idx_o,  m_idx);
            checkOutput("cyc btn_lvl_o", btn_lvl_o, m_lvl[N_CH-1:0]);
        end
    end

    initial begin
        // Reset state
        applyStimulus(0, 4'b0000, 0, 3);
        checkOutput("reset btn_o",    btn_o,    0);
        checkOutput("reset ch_idx_o", ch_idx_o, 0);
        checkOutput("reset busy_o",   busy_o,   0);
        checkOutput("reset d_inp_o",  d_inp_o,  0);
        rst_ni = 1'b1;
        applyStimulus(0, 4'b0000, 0, 2);

        // Single press latency: pulse after the 5th sampling edge
        applyStimulus(1, 4'b0000, 0, 2);
        checkOutput("s1 busy in wait", busy_o, 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, 4'b0100, 0, 1);
            checkOutput($sformatf("s1 d_inp_o edge %0d", k), d_inp_o, (k == 5) ? 1 : 0);
            if (k == 5) begin
                checkOutput("s1 btn_o",    btn_o,    4'b0100);
                checkOutput("s1 ch_idx_o", ch_idx_o, 2);
            end
            if (k == 6) checkOutput("s1 busy in done", busy_o, 0);
        end
        applyStimulus(0, 4'b0000, 0, 6);
        checkOutput("s1 btn_o held in idle", btn_o, 4'b0100);

        // Bounce on channel 1, then held
        applyStimulus(1, 4'b0000, 0, 2);
        cnt_d = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, (i % 2 == 0) ? 4'b0010 : 4'b0000, 0, 1);
            checkOutput($sformatf("s2 lvl1 bounce %0d", i), btn_lvl_o[1], 0);
        end
        applyStimulus(1, 4'b0010, 0, 8);
        checkOutput("s2 d pulses",  cnt_d,    1);
        checkOutput("s2 ch_idx_o",  ch_idx_o, 1);
        applyStimulus(0, 4'b0000, 0, 6);

        // Simultaneous press: lowest index wins
        applyStimulus(1, 4'b0000, 0, 2);
        cnt_d = 0;
        applyStimulus(1, 4'b1010, 0, 8);
        checkOutput("s4 d pulses", cnt_d,    1);
        checkOutput("s4 btn_o",    btn_o,    4'b0010);
        checkOutput("s4 ch_idx_o", ch_idx_o, 1);
        applyStimulus(0, 4'b1010, 0, 2);
        checkOutput("s4 busy idle",      busy_o, 0);
        checkOutput("s4 btn_o in idle",  btn_o,  4'b0010);
        applyStimulus(0, 4'b0000, 0, 6);

        // Timeout exactly 50 cycles after entering the wait
        applyStimulus(1, 4'b0000, 0, 2);
        cnt_to = 0;
        applyStimulus(1, 4'b0000, 0, 49);
        checkOutput("s5 no early timeout", cnt_to, 0);
        checkOutput("s5 busy before",      busy_o, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        checkOutput("s5 timeout_o",  timeout_o, 1);
        checkOutput("s5 btn_o",      btn_o,     0);
        checkOutput("s5 ch_idx_o",   ch_idx_o,  0);
        applyStimulus(1, 4'b0000, 0, 5);
        checkOutput("s5 one timeout", cnt_to, 1);
        checkOutput("s5 no rearm",    busy_o, 0);
        applyStimulus(0, 4'b0000, 0, 2);

        // Button held before the request is not captured
        applyStimulus(0, 4'b0001, 0, 6);
        cnt_d = 0;
        applyStimulus(1, 4'b0001, 0, 10);
        checkOutput("s3 no capture held", cnt_d,  0);
        checkOutput("s3 busy while held", busy_o, 1);
        applyStimulus(1, 4'b0000, 0, 6);
        applyStimulus(1, 4'b1000, 0, 8);
        checkOutput("s3 d pulses",  cnt_d,    1);
        checkOutput("s3 ch_idx_o",  ch_idx_o, 3);
        checkOutput("s3 btn_o",     btn_o,    4'b1000);
        applyStimulus(0, 4'b0000, 0, 6);

        // Abort in wait clears the held result, no pulses
        applyStimulus(1, 4'b0000, 0, 2);
        applyStimulus(1, 4'b0000, 0, 19);
        checkOutput("s5b busy waiting", busy_o, 1);
        checkOutput("s5b btn_o kept",   btn_o,  4'b1000);
        cnt_d  = 0;
        cnt_to = 0;
        applyStimulus(0, 4'b0000, 0, 1);
        checkOutput("s5b busy aborted", busy_o,   0);
        checkOutput("s5b btn_o clear",  btn_o,    0);
        checkOutput("s5b idx clear",    ch_idx_o, 0);
        applyStimulus(0, 4'b0000, 0, 60);
        checkOutput("s5b no d pulse",       cnt_d,  0);
        checkOutput("s5b no timeout pulse", cnt_to, 0);

        // User-reset press together with a button press
        applyStimulus(1, 4'b0000, 0, 2);
        cnt_d   = 0;
        cnt_rst = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1, 4'b0100, 1, 1);
            checkOutput($sformatf("s6 rst_o edge %0d", k), rst_o, (k == 5) ? 1 : 0);
            if (k == 5) begin
                checkOutput("s6 idle on rst", busy_o,  0);
                checkOutput("s6 d suppressed", d_inp_o, 0);
            end
        end
        checkOutput("s6 rst pulses", cnt_rst, 1);
        checkOutput("s6 d pulses",   cnt_d,   0);
        applyStimulus(0, 4'b0000, 0, 6);

        // Asynchronous reset while holding a result
        applyStimulus(1, 4'b0000, 0, 2);
        applyStimulus(1, 4'b0010, 0, 8);
        checkOutput("s7 btn_o before", btn_o, 4'b0010);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("s7 btn_o async",     btn_o,     0);
        checkOutput("s7 ch_idx_o async",  ch_idx_o,  0);
        checkOutput("s7 busy_o async",    busy_o,    0);
        checkOutput("s7 btn_lvl_o async", btn_lvl_o, 0);
        applyStimulus(0, 4'b0000, 0, 3);
        rst_ni = 1'b1;
        applyStimulus(0, 4'b0000, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
